mvu_job_sequencer: RTL

- Next-generation MVU task controller.
- Accepts a queue of up to DEPTH tagged jobs, each with its own cycle countdown, and runs them back to back.
- Supports stall via step, abort/flush, per-job done pulse with tag, and a sticky interrupt with acknowledge.
- Sits between the embedded-CPU command interface and the MVU datapath; run gates the datapath.

---
 rtl/mvu_jobseq_pkg.sv | 21 ++
 rtl/mvu_job_sequencer_if.sv | 39 +++
 rtl/mvu_job_fifo.sv | 66 ++++++
 rtl/mvu_job_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mvu_jobseq_pkg.sv
// Shared types for the MVU job sequencer.
//   state_t : one-hot controller state (IDLE / RUN / DONE)
//   job_t   : one queued job {countdown, tag} at the default widths
package mvu_jobseq_pkg;

  localparam int unsigned JOB_BCNTDWN = 29;
  localparam int unsigned JOB_BTAG    = 4;
  localparam int unsigned JOB_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  typedef struct packed {
    logic [JOB_BCNTDWN-1:0] countdown;
    logic [JOB_BTAG-1:0]    tag;
  } job_t;

endpackage

// File: rtl/mvu_job_sequencer_if.sv
// Command/status bundle between the CPU command side and the job sequencer.
//   master : CPU / datapath side (drives start, countdown, tag, step, abort, irq_ack)
//   slave  : the sequencer (drives ready, run, busy, level, remaining,
//            done, done_tag, done_abort, irq, stall_cnt)
interface mvu_job_sequencer_if #(
  parameter int BCNTDWN = 29,
  parameter int DEPTH   = 4,
  parameter int BTAG    = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic               start;
  logic [BCNTDWN-1:0] countdown;
  logic [BTAG-1:0]    tag;
  logic               ready;
  logic               step;
  logic               abort;
  logic               irq_ack;
  logic               run;
  logic               busy;
  logic [LW-1:0]      level;
  logic [BCNTDWN-1:0] remaining;
  logic               done;
  logic [BTAG-1:0]    done_tag;
  logic               done_abort;
  logic               irq;
  logic [31:0]        stall_cnt;

  modport master (
    output start, countdown, tag, step, abort, irq_ack,
    input  ready, run, busy, level, remaining, done, done_tag, done_abort, irq, stall_cnt
  );

  modport slave (
    input  start, countdown, tag, step, abort, irq_ack,
    output ready, run, busy, level, remaining, done, done_tag, done_abort, irq, stall_cnt
  );

endinterface

// File: rtl/mvu_job_fifo.sv
// Synchronous show-ahead FIFO holding queued jobs.
//   clk, clr : clock, synchronous active-high clear
//   flush    : empties the FIFO (wins over push/pop)
//   push,din : write request and data; ignored when full
//   pop      : read request; ignored when empty
//   dout     : head entry, valid whenever !empty
//   full, empty, level : occupancy status (registered)
module mvu_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_level == LVL_FULL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Head is read combinationally: the sequencer loads the job in the same
  // cycle it pops, so a registered read would add a bubble per job.
  assign dout = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mvu_job_sequencer.sv
// MVU job sequencer: queues up to DEPTH tagged jobs and runs their cycle
// countdowns back to back, gating the MVU datapath with run.
//   clk, clr : clock, synchronous active-high clear
//   bus      : mvu_job_sequencer_if.slave
//     in : start, countdown, tag (push), step (stall when 0), abort, irq_ack
//     out: ready, run, busy, level, remaining, done, done_tag, done_abort,
//          irq, stall_cnt
// Optional build macro MVU_JOBSEQ_STALLCNT_EN: when defined, stall_cnt counts
// step=0 cycles of the current/last job (saturating); otherwise it is 0.
module mvu_job_sequencer
  import mvu_jobseq_pkg::*;
#(
  parameter int BCNTDWN = 29,
  parameter int DEPTH   = 4,
  parameter int BTAG    = 4
) (
  input  logic                clk,
  input  logic                clr,
  mvu_job_sequencer_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int JW = BCNTDWN + BTAG;

  state_t             r_state;
  state_t             w_state_next;
  logic [BCNTDWN-1:0] r_counter;
  logic [BTAG-1:0]    r_cur_tag;
  logic [BTAG-1:0]    r_done_tag;
  logic               r_done_abort;
  logic               r_irq;

  logic               w_full;
  logic               w_empty;
  logic [LW-1:0]      w_level;
  logic [JW-1:0]      w_head;
  logic [BCNTDWN-1:0] w_head_cd;
  logic [BTAG-1:0]    w_head_tag;
  logic               w_push;
  logic               w_pop;
  logic               w_enter_done;
  logic               w_abort_done;

  // abort flushes the queue, so neither a push nor a pop may happen with it.
  assign w_push = bus.start && !w_full && !bus.abort;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty && !bus.abort;
  assign {w_head_cd, w_head_tag} = w_head;

  mvu_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JW)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (bus.abort),
    .push  (w_push),
    .din   ({bus.countdown, bus.tag}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        // A zero-length job goes straight to DONE without ever running.
        if (w_pop) w_state_next = (w_head_cd != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (bus.abort || (bus.step && (r_counter == BCNTDWN'(1))))
          w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    bus.run       = (r_state == ST_RUN);
    bus.done      = (r_state == ST_DONE);
    bus.busy      = (r_state != ST_IDLE) || !w_empty;
    bus.remaining = (r_state == ST_RUN) ? r_counter : '0;
  end

  assign w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);
  assign w_abort_done = (r_state == ST_RUN) && bus.abort;

  // Job datapath: countdown, tags and sticky interrupt.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_counter    <= '0;
      r_cur_tag    <= '0;
      r_done_tag   <= '0;
      r_done_abort <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_pop) begin
        r_counter <= w_head_cd;
        r_cur_tag <= w_head_tag;
      end else if ((r_state == ST_RUN) && bus.step && !bus.abort) begin
        r_counter <= r_counter - 1'b1;
      end
      // done_tag/done_abort are loaded on entry so they are already valid
      // during the DONE pulse; a zero-length job takes its tag from the head.
      if (w_enter_done) begin
        r_done_tag   <= (r_state == ST_IDLE) ? w_head_tag : r_cur_tag;
        r_done_abort <= w_abort_done;
      end
      if (w_enter_done)     r_irq <= 1'b1;
      else if (bus.irq_ack) r_irq <= 1'b0;
    end
  end

  assign bus.ready      = !w_full;
  assign bus.level      = w_level;
  assign bus.done_tag   = r_done_tag;
  assign bus.done_abort = r_done_abort;
  assign bus.irq        = r_irq;

`ifdef MVU_JOBSEQ_STALLCNT_EN
  logic [31:0] r_stall_cnt;

  // Cleared on pop, so it holds the last job's value through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (w_pop) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && !bus.step && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
